// File: rtl/ex2_stage_if.sv
// ============================================================================
// Module   : ex2_stage_if
// Purpose  : Bundle of signals between EX1/EX2 register, EX2 stage and the
//            EX2/WB register. Difftest fields exist only when
//            EX2_DIFFTEST_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex2_stage_if #(
   parameter int WAIT_CNT_W = 16
);
   logic                  flush;
   logic                  in_valid;
   logic                  ex2_allowin;
   logic                  wb_allowin;
   logic                  in_excp;
   logic [4:0]            in_rd0;
   logic [4:0]            in_rd1;
   logic [31:0]           in_res0;
   logic [31:0]           in_res1;
   logic                  in_res0_valid;
   logic                  in_res1_valid;
   logic [4:0]            in_rd2;
   logic [2:0]            in_op;
   logic [1:0]            in_mem_size;
   logic                  in_mem_unsigned;
   logic [1:0]            in_addr_lo;
   logic [31:0]           mul_hh;
   logic [31:0]           mul_hl;
   logic [31:0]           mul_lh;
   logic [31:0]           mul_ll;
   logic [31:0]           mul_comp;
   logic                  dcache_rready;
   logic [31:0]           dcache_rdata;
   logic                  div_ready;
   logic [31:0]           quotient;
   logic [31:0]           remainder;
   logic [31:0]           csr_rd_data;
   logic                  ex2_fwd_valid0;
   logic                  ex2_fwd_valid1;
   logic                  wb_valid;
   logic [4:0]            wb_rd0;
   logic [4:0]            wb_rd1;
   logic [4:0]            wb_rd2;
   logic [31:0]           wb_data0;
   logic [31:0]           wb_data1;
   logic [31:0]           wb_data2;
   logic                  wb_data0_valid;
   logic                  wb_data1_valid;
   logic                  wb_data2_valid;
   logic                  wb_excp;
   logic [WAIT_CNT_W-1:0] stall_cycles;
`ifdef EX2_DIFFTEST_EN
   logic [31:0]           in_pc0;
   logic [31:0]           in_pc1;
   logic [31:0]           in_inst0;
   logic [31:0]           in_inst1;
   logic [31:0]           wb_pc0;
   logic [31:0]           wb_pc1;
   logic [31:0]           wb_inst0;
   logic [31:0]           wb_inst1;
`endif

   // EX2 stage side
   modport slave (
      input  flush, in_valid, wb_allowin, in_excp, in_rd0, in_rd1, in_res0,
             in_res1, in_res0_valid, in_res1_valid, in_rd2, in_op,
             in_mem_size, in_mem_unsigned, in_addr_lo, mul_hh, mul_hl,
             mul_lh, mul_ll, mul_comp, dcache_rready, dcache_rdata,
             div_ready, quotient, remainder, csr_rd_data,
`ifdef EX2_DIFFTEST_EN
      input  in_pc0, in_pc1, in_inst0, in_inst1,
      output wb_pc0, wb_pc1, wb_inst0, wb_inst1,
`endif
      output ex2_allowin, ex2_fwd_valid0, ex2_fwd_valid1, wb_valid, wb_rd0,
             wb_rd1, wb_rd2, wb_data0, wb_data1, wb_data2, wb_data0_valid,
             wb_data1_valid, wb_data2_valid, wb_excp, stall_cycles
   );

   // Pipeline environment side
   modport master (
      output flush, in_valid, wb_allowin, in_excp, in_rd0, in_rd1, in_res0,
             in_res1, in_res0_valid, in_res1_valid, in_rd2, in_op,
             in_mem_size, in_mem_unsigned, in_addr_lo, mul_hh, mul_hl,
             mul_lh, mul_ll, mul_comp, dcache_rready, dcache_rdata,
             div_ready, quotient, remainder, csr_rd_data,
`ifdef EX2_DIFFTEST_EN
      output in_pc0, in_pc1, in_inst0, in_inst1,
      input  wb_pc0, wb_pc1, wb_inst0, wb_inst1,
`endif
      input  ex2_allowin, ex2_fwd_valid0, ex2_fwd_valid1, wb_valid, wb_rd0,
             wb_rd1, wb_rd2, wb_data0, wb_data1, wb_data2, wb_data0_valid,
             wb_data1_valid, wb_data2_valid, wb_excp, stall_cycles
   );
endinterface

`default_nettype wire

// File: rtl/ex2_stage.sv
// ============================================================================
// Module   : ex2_stage
// Purpose  : Second execute stage. Finishes slot-0 long ops (load, mul, div,
//            csr) and registers three write-back channels into EX2/WB.
//            Optional macro EX2_DIFFTEST_EN adds registered pc/inst fields.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex2_stage #(
   parameter int WAIT_CNT_W = 16
) (
   input  logic        clk,
   input  logic        aresetn,
   ex2_stage_if.slave  bus
);
   localparam logic [2:0] c_OP_NONE = 3'd0;
   localparam logic [2:0] c_OP_LOAD = 3'd1;
   localparam logic [2:0] c_OP_MULL = 3'd2;
   localparam logic [2:0] c_OP_MULH = 3'd3;
   localparam logic [2:0] c_OP_DIVQ = 3'd4;
   localparam logic [2:0] c_OP_DIVR = 3'd5;
   localparam logic [2:0] c_OP_CSR  = 3'd6;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_WAIT_MEM = 2'd1,
      ST_WAIT_DIV = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [WAIT_CNT_W-1:0] stall_q;
   logic                  ld_hold_q;
   logic [31:0]           ld_data_q;

   logic        w_is_load, w_is_div, w_need, w_done, w_retire;
   logic [63:0] w_mul_prod;
   logic [31:0] w_ld_word, w_ld_ext, w_data2;
   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;

   assign w_is_load = (bus.in_op == c_OP_LOAD);
   assign w_is_div  = (bus.in_op == c_OP_DIVQ) || (bus.in_op == c_OP_DIVR);
   assign w_need    = bus.in_valid & ~bus.in_excp & (w_is_load | w_is_div);
   // A load that already returned while WB was blocked counts as ready.
   assign w_done    = bus.in_valid &
                      (~w_need |
                       (w_is_load & (bus.dcache_rready | ld_hold_q)) |
                       (w_is_div & bus.div_ready));
   assign w_retire  = w_done & bus.wb_allowin;

   assign bus.ex2_allowin    = ~bus.in_valid | w_retire;
   assign bus.ex2_fwd_valid0 = bus.in_valid & bus.in_res0_valid & ~bus.in_excp;
   assign bus.ex2_fwd_valid1 = bus.in_valid & bus.in_res1_valid & ~bus.in_excp;
   assign bus.stall_cycles   = stall_q;

   // Each partial is widened to 64 bits before summing so carries are kept.
   assign w_mul_prod = {bus.mul_hh, 32'b0}
                     + {16'b0, bus.mul_hl, 16'b0}
                     + {16'b0, bus.mul_lh, 16'b0}
                     + {32'b0, bus.mul_ll}
                     + {bus.mul_comp, 32'b0};

   assign w_ld_word = ld_hold_q ? ld_data_q : bus.dcache_rdata;

   // Lane select and sign/zero extension of the returned load word
   always_comb begin
      w_ld_byte = w_ld_word[7:0];
      w_ld_half = bus.in_addr_lo[1] ? w_ld_word[31:16] : w_ld_word[15:0];
      w_ld_ext  = w_ld_word;
      case (bus.in_addr_lo)
         2'd1:    w_ld_byte = w_ld_word[15:8];
         2'd2:    w_ld_byte = w_ld_word[23:16];
         2'd3:    w_ld_byte = w_ld_word[31:24];
         default: w_ld_byte = w_ld_word[7:0];
      endcase
      case (bus.in_mem_size)
         2'd0:    w_ld_ext = bus.in_mem_unsigned ? {24'b0, w_ld_byte}
                                                 : {{24{w_ld_byte[7]}}, w_ld_byte};
         2'd1:    w_ld_ext = bus.in_mem_unsigned ? {16'b0, w_ld_half}
                                                 : {{16{w_ld_half[15]}}, w_ld_half};
         default: w_ld_ext = w_ld_word;
      endcase
   end

   // Long-op channel result mux
   always_comb begin
      w_data2 = 32'b0;
      case (bus.in_op)
         c_OP_LOAD: w_data2 = w_ld_ext;
         c_OP_MULL: w_data2 = w_mul_prod[31:0];
         c_OP_MULH: w_data2 = w_mul_prod[63:32];
         c_OP_DIVQ: w_data2 = bus.quotient;
         c_OP_DIVR: w_data2 = bus.remainder;
         c_OP_CSR:  w_data2 = bus.csr_rd_data;
         default:   w_data2 = 32'b0;
      endcase
   end

   // Next-state logic: wait for memory/divider, leave on retire or flush
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (w_need & ~w_done)
               state_d = w_is_load ? ST_WAIT_MEM : ST_WAIT_DIV;
         end
         ST_WAIT_MEM, ST_WAIT_DIV: begin
            if (w_retire)
               state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
      if (bus.flush)
         state_d = ST_RUN;
   end

   // State register and saturating stall counter
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_RUN;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q != ST_RUN && stall_q != {WAIT_CNT_W{1'b1}})
            stall_q <= stall_q + 1'b1;
      end
   end

   // Capture load data that arrives while WB is blocked so it is not lost
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         ld_hold_q <= 1'b0;
         ld_data_q <= 32'b0;
      end else if (bus.flush | w_retire) begin
         ld_hold_q <= 1'b0;
      end else if (w_need & w_is_load & bus.dcache_rready & ~ld_hold_q) begin
         ld_hold_q <= 1'b1;
         ld_data_q <= bus.dcache_rdata;
      end
   end

   // EX2/WB register: flush kills, retire loads, blocked WB holds
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         bus.wb_valid       <= 1'b0;
         bus.wb_rd0         <= 5'b0;
         bus.wb_rd1         <= 5'b0;
         bus.wb_rd2         <= 5'b0;
         bus.wb_data0       <= 32'b0;
         bus.wb_data1       <= 32'b0;
         bus.wb_data2       <= 32'b0;
         bus.wb_data0_valid <= 1'b0;
         bus.wb_data1_valid <= 1'b0;
         bus.wb_data2_valid <= 1'b0;
         bus.wb_excp        <= 1'b0;
`ifdef EX2_DIFFTEST_EN
         bus.wb_pc0         <= 32'b0;
         bus.wb_pc1         <= 32'b0;
         bus.wb_inst0       <= 32'b0;
         bus.wb_inst1       <= 32'b0;
`endif
      end else if (bus.flush) begin
         bus.wb_valid <= 1'b0;
      end else if (w_retire) begin
         bus.wb_valid       <= 1'b1;
         bus.wb_rd0         <= bus.in_rd0;
         bus.wb_rd1         <= bus.in_rd1;
         bus.wb_rd2         <= bus.in_rd2;
         bus.wb_data0       <= bus.in_res0;
         bus.wb_data1       <= bus.in_res1;
         bus.wb_data2       <= w_data2;
         bus.wb_data0_valid <= bus.in_res0_valid & ~bus.in_excp & (bus.in_rd0 != 5'd0);
         bus.wb_data1_valid <= bus.in_res1_valid & ~bus.in_excp & (bus.in_rd1 != 5'd0);
         bus.wb_data2_valid <= (bus.in_op != c_OP_NONE) & ~bus.in_excp & (bus.in_rd2 != 5'd0);
         bus.wb_excp        <= bus.in_excp;
`ifdef EX2_DIFFTEST_EN
         bus.wb_pc0         <= bus.in_pc0;
         bus.wb_pc1         <= bus.in_pc1;
         bus.wb_inst0       <= bus.in_inst0;
         bus.wb_inst1       <= bus.in_inst1;
`endif
      end else if (bus.wb_allowin) begin
         bus.wb_valid <= 1'b0;
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_ex2_stage.sv
// ============================================================================
// Module   : tb_ex2_stage
// Purpose  : Directed self-checking bench for ex2_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex2_stage;
   logic clk;
   logic aresetn;
   int   errors;
   int   checks;

   ex2_stage_if #(.WAIT_CNT_W(16)) bus ();

   ex2_stage #(.WAIT_CNT_W(16)) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs are then changed 1ns after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      bus.flush = 0; bus.in_valid = 0; bus.wb_allowin = 1; bus.in_excp = 0;
      bus.in_rd0 = 0; bus.in_rd1 = 0; bus.in_rd2 = 0;
      bus.in_res0 = 0; bus.in_res1 = 0; bus.in_res0_valid = 0; bus.in_res1_valid = 0;
      bus.in_op = 0; bus.in_mem_size = 0; bus.in_mem_unsigned = 0; bus.in_addr_lo = 0;
      bus.mul_hh = 0; bus.mul_hl = 0; bus.mul_lh = 0; bus.mul_ll = 0; bus.mul_comp = 0;
      bus.dcache_rready = 0; bus.dcache_rdata = 0; bus.div_ready = 0;
      bus.quotient = 0; bus.remainder = 0; bus.csr_rd_data = 0;
`ifdef EX2_DIFFTEST_EN
      bus.in_pc0 = 0; bus.in_pc1 = 0; bus.in_inst0 = 0; bus.in_inst1 = 0;
`endif
   endtask

   task automatic test_reset();
      idle_bus();
      aresetn = 0;
      #12;
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%h want=0", bus.wb_valid); end
      checks++; if (bus.stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall got=%h want=0", bus.stall_cycles); end
      checks++; if (bus.wb_data2 !== 32'd0) begin errors++; $display("FAIL reset_wb_data2 got=%h want=0", bus.wb_data2); end
      checks++; if (bus.ex2_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got=%h want=1", bus.ex2_allowin); end
      aresetn = 1;
      step();
   endtask

   task automatic test_alu();
      bus.in_valid = 1; bus.in_res0 = 32'h12345678; bus.in_rd0 = 5; bus.in_res0_valid = 1;
      bus.in_res1 = 32'hFFFFFFFF; bus.in_rd1 = 0; bus.in_res1_valid = 1;
      #1;
      checks++; if (bus.ex2_allowin !== 1'b1) begin errors++; $display("FAIL alu_allowin got=%h want=1", bus.ex2_allowin); end
      checks++; if (bus.ex2_fwd_valid1 !== 1'b1) begin errors++; $display("FAIL alu_fwd1 got=%h want=1", bus.ex2_fwd_valid1); end
      step();
      checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wb_valid got=%h want=1", bus.wb_valid); end
      checks++; if (bus.wb_data0 !== 32'h12345678) begin errors++; $display("FAIL alu_data0 got=%h want=12345678", bus.wb_data0); end
      checks++; if (bus.wb_rd0 !== 5'd5) begin errors++; $display("FAIL alu_rd0 got=%h want=5", bus.wb_rd0); end
      checks++; if (bus.wb_data0_valid !== 1'b1) begin errors++; $display("FAIL alu_d0v got=%h want=1", bus.wb_data0_valid); end
      checks++; if (bus.wb_data1_valid !== 1'b0) begin errors++; $display("FAIL alu_d1v_r0 got=%h want=0", bus.wb_data1_valid); end
      checks++; if (bus.wb_data2_valid !== 1'b0) begin errors++; $display("FAIL alu_d2v got=%h want=0", bus.wb_data2_valid); end
      idle_bus();
      step();
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL alu_bubble got=%h want=0", bus.wb_valid); end
   endtask

   task automatic test_load_wait();
      bus.in_valid = 1; bus.in_op = 3'd1; bus.in_mem_size = 2'd0; bus.in_mem_unsigned = 0;
      bus.in_addr_lo = 2'd3; bus.in_rd2 = 5'd7; bus.dcache_rdata = 32'h80ABCDEF;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (bus.ex2_allowin !== 1'b0) begin errors++; $display("FAIL ldw_allowin%0d got=%h want=0", k, bus.ex2_allowin); end
         step();
      end
      bus.dcache_rready = 1;
      #1;
      checks++; if (bus.ex2_allowin !== 1'b1) begin errors++; $display("FAIL ldw_allowin_ready got=%h want=1", bus.ex2_allowin); end
      step();
      checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL ldw_wb_valid got=%h want=1", bus.wb_valid); end
      checks++; if (bus.wb_data2 !== 32'hFFFFFF80) begin errors++; $display("FAIL ldw_data2 got=%h want=ffffff80", bus.wb_data2); end
      checks++; if (bus.wb_data2_valid !== 1'b1) begin errors++; $display("FAIL ldw_d2v got=%h want=1", bus.wb_data2_valid); end
      checks++; if (bus.stall_cycles !== 16'd4) begin errors++; $display("FAIL ldw_stall got=%0d want=4", bus.stall_cycles); end
      idle_bus();
      // unsigned half from upper lane: 0x80AB zero-extended
      bus.in_valid = 1; bus.in_op = 3'd1; bus.in_mem_size = 2'd1; bus.in_mem_unsigned = 1;
      bus.in_addr_lo = 2'd2; bus.in_rd2 = 5'd7; bus.dcache_rdata = 32'h80ABCDEF; bus.dcache_rready = 1;
      step();
      checks++; if (bus.wb_data2 !== 32'h000080AB) begin errors++; $display("FAIL ldh_data2 got=%h want=000080ab", bus.wb_data2); end
      idle_bus();
   endtask

   task automatic test_mul();
      // signed 0xFFFFFFFF * 2: unsigned halves plus -b<<32 correction
      bus.in_valid = 1; bus.in_op = 3'd3; bus.in_rd2 = 5'd8;
      bus.mul_hh = 32'h0; bus.mul_hl = 32'h0001FFFE; bus.mul_lh = 32'h0;
      bus.mul_ll = 32'h0001FFFE; bus.mul_comp = 32'hFFFFFFFE;
      step();
      checks++; if (bus.wb_data2 !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulh_data2 got=%h want=ffffffff", bus.wb_data2); end
      bus.in_op = 3'd2;
      step();
      checks++; if (bus.wb_data2 !== 32'hFFFFFFFE) begin errors++; $display("FAIL mull_data2 got=%h want=fffffffe", bus.wb_data2); end
      checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL mull_b2b_valid got=%h want=1", bus.wb_valid); end
      bus.in_op = 3'd6; bus.csr_rd_data = 32'h0BADF00D;
      step();
      checks++; if (bus.wb_data2 !== 32'h0BADF00D) begin errors++; $display("FAIL csr_data2 got=%h want=0badf00d", bus.wb_data2); end
      idle_bus();
   endtask

   task automatic test_flush();
      bus.in_valid = 1; bus.in_op = 3'd5; bus.in_rd2 = 5'd9; bus.remainder = 32'h55;
      step();                       // RUN -> WAIT_DIV
      step();                       // wait cycle 1
      step();                       // wait cycle 2
      bus.flush = 1; bus.div_ready = 1;   // wait cycle 3: flush beats retire
      step();
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wb_valid got=%h want=0", bus.wb_valid); end
      checks++; if (bus.stall_cycles !== 16'd7) begin errors++; $display("FAIL flush_stall got=%0d want=7", bus.stall_cycles); end
      idle_bus();
      bus.in_valid = 1; bus.in_res0 = 32'hA5A5A5A5; bus.in_rd0 = 5'd3; bus.in_res0_valid = 1;
      step();
      checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL flush_next_valid got=%h want=1", bus.wb_valid); end
      checks++; if (bus.wb_data0 !== 32'hA5A5A5A5) begin errors++; $display("FAIL flush_next_data0 got=%h want=a5a5a5a5", bus.wb_data0); end
      checks++; if (bus.stall_cycles !== 16'd7) begin errors++; $display("FAIL flush_run_stall got=%0d want=7", bus.stall_cycles); end
      idle_bus();
   endtask

   task automatic test_hold();
      bus.in_valid = 1; bus.in_res0 = 32'h0000BEEF; bus.in_rd0 = 5'd2; bus.in_res0_valid = 1;
      step();
      idle_bus();
      bus.in_valid = 1; bus.in_op = 3'd1; bus.in_mem_size = 2'd2; bus.in_rd2 = 5'd9;
      bus.dcache_rready = 1; bus.dcache_rdata = 32'hCAFEBABE; bus.wb_allowin = 0;
      #1;
      checks++; if (bus.ex2_allowin !== 1'b0) begin errors++; $display("FAIL hold_allowin got=%h want=0", bus.ex2_allowin); end
      step();
      checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL hold1_valid got=%h want=1", bus.wb_valid); end
      checks++; if (bus.wb_data0 !== 32'h0000BEEF) begin errors++; $display("FAIL hold1_data0 got=%h want=0000beef", bus.wb_data0); end
      bus.dcache_rready = 0; bus.dcache_rdata = 32'h11111111;
      step();
      checks++; if (bus.wb_rd0 !== 5'd2) begin errors++; $display("FAIL hold2_rd0 got=%h want=2", bus.wb_rd0); end
      bus.wb_allowin = 1;
      #1;
      checks++; if (bus.ex2_allowin !== 1'b1) begin errors++; $display("FAIL hold_release_allowin got=%h want=1", bus.ex2_allowin); end
      step();
      checks++; if (bus.wb_data2 !== 32'hCAFEBABE) begin errors++; $display("FAIL hold_data2 got=%h want=cafebabe", bus.wb_data2); end
      checks++; if (bus.wb_rd2 !== 5'd9) begin errors++; $display("FAIL hold_rd2 got=%h want=9", bus.wb_rd2); end
      idle_bus();
   endtask

   task automatic test_excp_reset();
      bus.in_valid = 1; bus.in_excp = 1; bus.in_op = 3'd1; bus.in_rd2 = 5'd6;
      bus.in_res0_valid = 1; bus.in_rd0 = 5'd4;
      #1;
      checks++; if (bus.ex2_allowin !== 1'b1) begin errors++; $display("FAIL excp_allowin got=%h want=1", bus.ex2_allowin); end
      checks++; if (bus.ex2_fwd_valid0 !== 1'b0) begin errors++; $display("FAIL excp_fwd0 got=%h want=0", bus.ex2_fwd_valid0); end
      step();
      checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL excp_valid got=%h want=1", bus.wb_valid); end
      checks++; if (bus.wb_excp !== 1'b1) begin errors++; $display("FAIL excp_flag got=%h want=1", bus.wb_excp); end
      checks++; if ({bus.wb_data0_valid, bus.wb_data1_valid, bus.wb_data2_valid} !== 3'b000) begin
         errors++; $display("FAIL excp_dv got=%b want=000", {bus.wb_data0_valid, bus.wb_data1_valid, bus.wb_data2_valid}); end
      idle_bus();
      bus.in_valid = 1; bus.in_op = 3'd1; bus.in_rd2 = 5'd6;
      step();
      step();
      #2 aresetn = 0;
      #1;
      checks++; if (bus.stall_cycles !== 16'd0) begin errors++; $display("FAIL arst_stall got=%0d want=0", bus.stall_cycles); end
      checks++; if (bus.wb_excp !== 1'b0) begin errors++; $display("FAIL arst_excp got=%h want=0", bus.wb_excp); end
      checks++; if (bus.wb_rd0 !== 5'd0) begin errors++; $display("FAIL arst_rd0 got=%h want=0", bus.wb_rd0); end
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%h want=0", bus.wb_valid); end
      idle_bus();
      #10 aresetn = 1;
      step();
      step();
      checks++; if (bus.stall_cycles !== 16'd0) begin errors++; $display("FAIL arst_run_stall got=%0d want=0", bus.stall_cycles); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_alu();
      test_load_wait();
      test_mul();
      test_flush();
      test_hold();
      test_excp_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
